// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
// Holds the clear/run state encoding, the hardwired-zero index and packed-port slicing helpers.
package regfile_pkg;

   typedef enum logic [0:0] {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_e;

   localparam int unsigned RF_ZERO_IDX = 0;

   // LSB position of port k inside a packed bus of w-bit fields
   function automatic int unsigned port_lsb(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

   function automatic logic is_zero_idx(input int unsigned idx);
      return idx == RF_ZERO_IDX;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps registers 1..DEPTH-1 to zero after reset or on clear_req.
// Latency: ready rises DEPTH-1 edges after reset release or after the accepting clear_req edge.
// Backpressure: ready=0 while sweeping; clear_req is only accepted while ready=1.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_req,
   output logic          ready,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   rf_state_e     state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RF_CLEAR;
         ptr_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      clr_we  = 1'b0;
      case (state_q)
         RF_CLEAR: begin
            clr_we = 1'b1;
            ptr_d  = ptr_q + AW'(1);
            // The last storage index finishes the sweep; register 0 is never swept
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d = RF_RUN;
            end
         end
         RF_RUN: begin
            if (clear_req) begin
               state_d = RF_CLEAR;
               ptr_d   = AW'(1);
            end
         end
         default: begin
            state_d = RF_CLEAR;
            ptr_d   = AW'(1);
         end
      endcase
   end

   assign ready    = (state_q == RF_RUN);
   assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with busy scoreboard and sweep clear; REGFILE_BYPASS_EN adds write-to-read forwarding.
// Latency: reads combinational, writes/busy visible next cycle (same cycle for forwarded data with REGFILE_BYPASS_EN).
// Backpressure: ready=0 during the clear sweep; writes, issues and clear requests are then ignored.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 32,
   parameter int NREAD   = 2,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear_req,
   output logic                   ready,
   input  logic                   w_en,
   input  logic [AW-1:0]          w_addr,
   input  logic [WIDTH-1:0]       w_data,
   input  logic                   issue_en,
   input  logic [AW-1:0]          issue_addr,
   input  logic [NREAD*AW-1:0]    r_addr,
   output logic [NREAD*WIDTH-1:0] r_data,
   output logic [NREAD-1:0]       r_busy
);

   logic [WIDTH-1:0] regs [1:DEPTH-1];
   logic [DEPTH-1:1] busy_q;

   logic          clr_we;
   logic [AW-1:0] clr_addr;
   logic          wr_ok;
   logic          iss_ok;
   logic          clr_start;

   regfile_clear_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_req (clear_req),
      .ready     (ready),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   assign wr_ok     = ready && w_en && !is_zero_idx(int'(w_addr));
   assign iss_ok    = ready && issue_en && !is_zero_idx(int'(issue_addr));
   assign clr_start = ready && clear_req;

   // Array has no reset of its own; the sweep zeroes it once reset releases
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (clr_we) begin
            regs[clr_addr] <= '0;
         end else if (wr_ok) begin
            regs[w_addr] <= w_data;
         end
      end
   end

   // Issue is applied after writeback so a same-edge issue leaves the register busy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else if (clr_start) begin
         busy_q <= '0;
      end else begin
         if (wr_ok) begin
            busy_q[w_addr] <= 1'b0;
         end
         if (iss_ok) begin
            busy_q[issue_addr] <= 1'b1;
         end
      end
   end

   always_comb begin
      logic [AW-1:0] ra;
      r_data = '0;
      r_busy = '0;
      for (int k = 0; k < NREAD; k++) begin
         ra = r_addr[port_lsb(k, AW) +: AW];
         if (ready && !is_zero_idx(int'(ra))) begin
            r_data[port_lsb(k, WIDTH) +: WIDTH] = regs[ra];
            r_busy[k]                           = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (ra == w_addr)) begin
               r_data[port_lsb(k, WIDTH) +: WIDTH] = w_data;
               r_busy[k]                           = 1'b0;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-level reference model.
module tb_regfile_mp;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int NREAD = 2;
   localparam int AW    = $clog2(DEPTH);

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   clear_req;
   logic                   ready;
   logic                   w_en;
   logic [AW-1:0]          w_addr;
   logic [WIDTH-1:0]       w_data;
   logic                   issue_en;
   logic [AW-1:0]          issue_addr;
   logic [NREAD*AW-1:0]    r_addr;
   logic [NREAD*WIDTH-1:0] r_data;
   logic [NREAD-1:0]       r_busy;

   always #5 clk = ~clk;

   regfile_mp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .NREAD (NREAD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_req  (clear_req),
      .ready      (ready),
      .w_en       (w_en),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .r_addr     (r_addr),
      .r_data     (r_data),
      .r_busy     (r_busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: architectural view of registers, busy flags and sweep countdown
   logic [WIDTH-1:0] m_regs [DEPTH];
   bit               m_busy [DEPTH];
   bit               m_ready;
   int               m_left;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int a;
      logic [WIDTH-1:0] ed;
      bit eb;
      chk("ready", 64'(ready), 64'(m_ready));
      for (int k = 0; k < NREAD; k++) begin
         a  = int'(r_addr[k*AW +: AW]);
         ed = '0;
         eb = 1'b0;
         if (m_ready && a != 0) begin
            ed = m_regs[a];
            eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (w_en && w_addr != 0 && int'(w_addr) == a) begin
               ed = w_data;
               eb = 1'b0;
            end
`endif
         end
         chk($sformatf("r_data%0d@x%0d", k, a), 64'(r_data[k*WIDTH +: WIDTH]), 64'(ed));
         chk($sformatf("r_busy%0d@x%0d", k, a), 64'(r_busy[k]), 64'(eb));
      end
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         m_ready = 1'b0;
         m_left  = DEPTH - 1;
         foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else if (!m_ready) begin
         m_left--;
         if (m_left == 0) begin
            m_ready = 1'b1;
            foreach (m_regs[i]) m_regs[i] = '0;
         end
      end else begin
         if (w_en && w_addr != 0) begin
            m_regs[w_addr] = w_data;
            m_busy[w_addr] = 1'b0;
         end
         if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
         if (clear_req) begin
            m_ready = 1'b0;
            m_left  = DEPTH - 1;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
         end
      end
   endtask

   // Inputs are driven at the falling edge; outputs checked shortly after, model advanced at the rising edge
   task automatic step();
      #2;
      check_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      clear_req  = 1'b0;
      w_en       = 1'b0;
      issue_en   = 1'b0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      r_addr[0*AW +: AW] = AW'(a0);
      r_addr[1*AW +: AW] = AW'(a1);
   endtask

   task automatic wr(input int a, input logic [WIDTH-1:0] d);
      w_en   = 1'b1;
      w_addr = AW'(a);
      w_data = d;
   endtask

   task automatic iss(input int a);
      issue_en   = 1'b1;
      issue_addr = AW'(a);
   endtask

   task automatic count_sweep(input string tag);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk(tag, 64'(n), 64'(DEPTH - 1));
   endtask

   initial begin
      rst_n      = 1'b0;
      w_addr     = '0;
      w_data     = '0;
      issue_addr = '0;
      idle();
      set_rd(5, 0);
      @(negedge clk);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      step();
      step();
      rst_n = 1'b1;
      set_rd(1, 31);
      count_sweep("reset_sweep_len");
      step();

      wr(5, 32'hDEADBEEF); set_rd(5, 5); step();
      idle(); step();
      chk("x5_port0", 64'(r_data[0 +: WIDTH]), 64'h0000_0000_DEAD_BEEF);
      chk("x5_port1", 64'(r_data[WIDTH +: WIDTH]), 64'h0000_0000_DEAD_BEEF);
      wr(0, 32'h1234); set_rd(0, 0); step();
      idle(); step();

      iss(7); set_rd(7, 7); step();
      idle(); step();
      chk("x7_busy", 64'(r_busy), 64'h3);
      wr(7, 32'h55); step();
      idle(); step();
      wr(7, 32'h66); iss(7); step();
      idle(); step();
      chk("x7_data_after_iss_wr", 64'(r_data[0 +: WIDTH]), 64'h66);
      chk("x7_busy_after_iss_wr", 64'(r_busy[0]), 64'h1);

      wr(3, 32'hA); set_rd(3, 7); step();
      idle(); clear_req = 1'b1; step();
      clear_req = 1'b0; wr(3, 32'hBB); iss(3);
      count_sweep("clear_sweep_len");
      idle(); step();
      chk("x3_after_clear", 64'(r_data[0 +: WIDTH]), 64'h0);

      wr(11, 32'hCAFE); step();
      idle(); clear_req = 1'b1; step();
      clear_req = 1'b0;
      for (int i = 0; i < 10; i++) step();
      rst_n = 1'b0; step();
      rst_n = 1'b1; set_rd(11, 1);
      count_sweep("midsweep_reset_len");
      step();

      wr(9, 32'h77); set_rd(9, 9); step();
      idle(); step();
      chk("x9_after_write", 64'(r_data[0 +: WIDTH]), 64'h77);

      for (int c = 0; c < 1500; c++) begin
         rst_n      = ($urandom_range(0, 299) != 0);
         clear_req  = ($urandom_range(0, 59) == 0);
         w_en       = ($urandom_range(0, 2) != 0);
         w_addr     = AW'($urandom_range(0, DEPTH - 1));
         w_data     = $urandom;
         issue_en   = ($urandom_range(0, 2) == 0);
         issue_addr = ($urandom_range(0, 3) == 0) ? w_addr : AW'($urandom_range(0, DEPTH - 1));
         set_rd(($urandom_range(0, 3) == 0) ? int'(w_addr) : int'($urandom_range(0, DEPTH - 1)),
                int'($urandom_range(0, DEPTH - 1)));
         step();
      end
      idle();
      rst_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
